// File: rtl/mgmt_mdio_pkg.sv
// Shared types and register-map constants for the MDIO channel bank.
package mgmt_mdio_pkg;

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} chan_state_t;

  localparam logic [15:0] OFF_IRQSTAT = 16'h0000;
  localparam logic [15:0] OFF_IRQMASK = 16'h0001;
  localparam logic [15:0] OFF_CH_BASE = 16'h0008;
  localparam int          CH_STRIDE   = 4;

  localparam int STAT_BUSY_BIT = 7;
  localparam int STAT_DONE_BIT = 6;
  localparam int STAT_ERR_BIT  = 5;
  localparam int CMD_WR_BIT    = 6;
  localparam int CMD_RD_BIT    = 5;

  // Word index (offset >> 2) of a channel window; every window is 4 bytes wide.
  function automatic logic [13:0] ch_word(input int ch);
    return 14'((int'(OFF_CH_BASE) + CH_STRIDE * ch) >> 2);
  endfunction

endpackage

// File: rtl/mgmt_mdio_channel_fsm.sv
// One MDIO channel: command window registers and request/complete state machine.
// Busy timeout counter is built only when MGMT_MDIO_TIMEOUT_EN is defined.
module mgmt_mdio_channel_fsm
  import mgmt_mdio_pkg::*;
#(
  parameter int START_WAIT     = 15,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr_en,
  input  logic [1:0]  i_wr_sel,
  input  logic [7:0]  i_wr_data,
  input  logic        i_mdio_busy,
  input  logic [15:0] i_phy_rd_data,
  output logic [15:0] o_data,
  output logic [4:0]  o_md_addr,
  output logic [4:0]  o_reg_addr,
  output logic [7:0]  o_status,
  output logic        o_phy_reg_rd,
  output logic        o_phy_reg_wr,
  output logic        o_done_evt
);

  localparam int SW_W = (START_WAIT > 1) ? $clog2(START_WAIT) : 1;

  chan_state_t     r_state;
  logic [15:0]     r_data;
  logic [4:0]      r_md_addr;
  logic [4:0]      r_reg_addr;
  logic            r_done;
  logic            r_err;
  logic            r_is_rd;
  logic            r_phy_reg_rd;
  logic            r_phy_reg_wr;
  logic [SW_W-1:0] r_start_cnt;
`ifdef MGMT_MDIO_TIMEOUT_EN
  logic [15:0]     r_to_cnt;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  logic w_idle;
  logic w_cmd_wr;
  logic w_cmd_rd;
  logic w_cmd;

  assign w_idle   = (r_state == IDLE);
  assign w_cmd_wr = i_wr_en && (i_wr_sel == 2'd3) && i_wr_data[CMD_WR_BIT];
  assign w_cmd_rd = i_wr_en && (i_wr_sel == 2'd3) && i_wr_data[CMD_RD_BIT];
  assign w_cmd    = w_cmd_wr || w_cmd_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_data       <= '0;
      r_md_addr    <= '0;
      r_reg_addr   <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_is_rd      <= 1'b0;
      r_phy_reg_rd <= 1'b0;
      r_phy_reg_wr <= 1'b0;
      r_start_cnt  <= '0;
`ifdef MGMT_MDIO_TIMEOUT_EN
      r_to_cnt     <= '0;
`endif
    end else begin
      r_phy_reg_rd <= 1'b0;
      r_phy_reg_wr <= 1'b0;
      if (w_cmd && !w_idle) r_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (i_wr_en) begin
            case (i_wr_sel)
              2'd0: r_data[7:0]  <= i_wr_data;
              2'd1: r_data[15:8] <= i_wr_data;
              2'd2: begin
                r_md_addr[2:0] <= i_wr_data[7:5];
                r_reg_addr     <= i_wr_data[4:0];
              end
              default: r_md_addr[4:3] <= i_wr_data[1:0];
            endcase
          end
          if (w_cmd) begin
            // Write takes priority when both request bits are set.
            r_state      <= START;
            r_start_cnt  <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_is_rd      <= !w_cmd_wr;
            r_phy_reg_wr <= w_cmd_wr;
            r_phy_reg_rd <= !w_cmd_wr;
`ifdef MGMT_MDIO_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
          end
        end
        START: begin
          if (i_mdio_busy) r_state <= BUSY;
          else if (r_start_cnt == SW_W'(START_WAIT - 1)) r_state <= DONE;
          else r_start_cnt <= r_start_cnt + SW_W'(1);
        end
        BUSY: begin
          if (!i_mdio_busy) begin
            r_state <= DONE;
            if (r_is_rd) r_data <= i_phy_rd_data;
          end
`ifdef MGMT_MDIO_TIMEOUT_EN
          else if (r_to_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            r_err   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
`endif
        end
        default: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_data       = r_data;
  assign o_md_addr    = r_md_addr;
  assign o_reg_addr   = r_reg_addr;
  assign o_status     = {!w_idle, r_done, r_err, 3'b000, r_md_addr[4:3]};
  assign o_phy_reg_rd = r_phy_reg_rd;
  assign o_phy_reg_wr = r_phy_reg_wr;
  assign o_done_evt   = (r_state == DONE);

endmodule

// File: rtl/mgmt_mdio_channel_bank.sv
// Bank of NUM_CHANNELS MDIO command windows with sticky, maskable completion IRQs.
// Optional busy timeout per channel: define MGMT_MDIO_TIMEOUT_EN.
module mgmt_mdio_channel_bank
  import mgmt_mdio_pkg::*;
#(
  parameter int          NUM_CHANNELS   = 4,
  parameter logic [15:0] BASE_ADDR      = 16'h0048,
  parameter int          START_WAIT     = 15,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_en,
  input  logic [15:0]               rd_addr,
  output logic                      rd_valid,
  output logic [7:0]                rd_data,
  input  logic                      wr_en,
  input  logic [15:0]               wr_addr,
  input  logic [7:0]                wr_data,
  output logic                      irq,
  input  logic [NUM_CHANNELS-1:0]   mdio_busy,
  input  logic [16*NUM_CHANNELS-1:0] phy_rd_data,
  output logic [16*NUM_CHANNELS-1:0] phy_wr_data,
  output logic [5*NUM_CHANNELS-1:0] phy_reg_addr,
  output logic [5*NUM_CHANNELS-1:0] phy_md_addr,
  output logic [NUM_CHANNELS-1:0]   phy_reg_wr,
  output logic [NUM_CHANNELS-1:0]   phy_reg_rd
);

  logic [15:0]             w_rd_off;
  logic [15:0]             w_wr_off;
  logic [NUM_CHANNELS-1:0] w_done_evt;
  logic [NUM_CHANNELS-1:0] w_stat_clr;
  logic [15:0]             w_data     [NUM_CHANNELS];
  logic [4:0]              w_md_addr  [NUM_CHANNELS];
  logic [4:0]              w_reg_addr [NUM_CHANNELS];
  logic [7:0]              w_status   [NUM_CHANNELS];
  logic [7:0]              w_rd_mux;

  logic [NUM_CHANNELS-1:0] r_irq_stat;
  logic [NUM_CHANNELS-1:0] r_irq_mask;
  logic                    r_irq;
  logic                    r_rd_valid;
  logic [7:0]              r_rd_data;

  // Addresses below BASE_ADDR wrap to large offsets and so decode as unmapped.
  assign w_rd_off = rd_addr - BASE_ADDR;
  assign w_wr_off = wr_addr - BASE_ADDR;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      logic w_ch_wr;
      assign w_ch_wr = wr_en && (w_wr_off[15:2] == ch_word(gi));

      mgmt_mdio_channel_fsm #(
        .START_WAIT     (START_WAIT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
      ) u_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wr_en       (w_ch_wr),
        .i_wr_sel      (w_wr_off[1:0]),
        .i_wr_data     (wr_data),
        .i_mdio_busy   (mdio_busy[gi]),
        .i_phy_rd_data (phy_rd_data[16*gi +: 16]),
        .o_data        (w_data[gi]),
        .o_md_addr     (w_md_addr[gi]),
        .o_reg_addr    (w_reg_addr[gi]),
        .o_status      (w_status[gi]),
        .o_phy_reg_rd  (phy_reg_rd[gi]),
        .o_phy_reg_wr  (phy_reg_wr[gi]),
        .o_done_evt    (w_done_evt[gi])
      );

      assign phy_wr_data[16*gi +: 16] = w_data[gi];
      assign phy_md_addr[5*gi +: 5]   = w_md_addr[gi];
      assign phy_reg_addr[5*gi +: 5]  = w_reg_addr[gi];
    end
  endgenerate

  always_comb begin
    w_rd_mux = '0;
    if (w_rd_off == OFF_IRQSTAT) w_rd_mux[NUM_CHANNELS-1:0] = r_irq_stat;
    else if (w_rd_off == OFF_IRQMASK) w_rd_mux[NUM_CHANNELS-1:0] = r_irq_mask;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (w_rd_off[15:2] == ch_word(i)) begin
        case (w_rd_off[1:0])
          2'd0:    w_rd_mux = w_data[i][7:0];
          2'd1:    w_rd_mux = w_data[i][15:8];
          2'd2:    w_rd_mux = {w_md_addr[i][2:0], w_reg_addr[i]};
          default: w_rd_mux = w_status[i];
        endcase
      end
    end
  end

  assign w_stat_clr = (wr_en && (w_wr_off == OFF_IRQSTAT)) ? wr_data[NUM_CHANNELS-1:0] : '0;

  // A completion in the same cycle as a W1C of that bit leaves the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_stat <= '0;
      r_irq_mask <= '0;
      r_irq      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_irq_stat <= (r_irq_stat & ~w_stat_clr) | w_done_evt;
      if (wr_en && (w_wr_off == OFF_IRQMASK)) r_irq_mask <= wr_data[NUM_CHANNELS-1:0];
      r_irq      <= |(r_irq_stat & r_irq_mask);
      r_rd_valid <= rd_en;
      r_rd_data  <= rd_en ? w_rd_mux : 8'h00;
    end
  end

  assign irq      = r_irq;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_mgmt_mdio_channel_bank.sv
// Self-checking bench for mgmt_mdio_channel_bank with a transaction-level register model.
module tb_mgmt_mdio_channel_bank;

  localparam int          NCH  = 4;
  localparam logic [15:0] BASE = 16'h0048;
  localparam int          SW   = 15;
  localparam int          TO   = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd_en = 1'b0;
  logic [15:0]       rd_addr = '0;
  logic              rd_valid;
  logic [7:0]        rd_data;
  logic              wr_en = 1'b0;
  logic [15:0]       wr_addr = '0;
  logic [7:0]        wr_data = '0;
  logic              irq;
  logic [NCH-1:0]    mdio_busy = '0;
  logic [16*NCH-1:0] phy_rd_data = '0;
  logic [16*NCH-1:0] phy_wr_data;
  logic [5*NCH-1:0]  phy_reg_addr;
  logic [5*NCH-1:0]  phy_md_addr;
  logic [NCH-1:0]    phy_reg_wr;
  logic [NCH-1:0]    phy_reg_rd;

  mgmt_mdio_channel_bank #(
    .NUM_CHANNELS(NCH), .BASE_ADDR(BASE), .START_WAIT(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .irq(irq),
    .mdio_busy(mdio_busy), .phy_rd_data(phy_rd_data), .phy_wr_data(phy_wr_data),
    .phy_reg_addr(phy_reg_addr), .phy_md_addr(phy_md_addr), .phy_reg_wr(phy_reg_wr),
    .phy_reg_rd(phy_reg_rd)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Request-pulse monitor: counts pulses and records the address presented with each.
  int         rd_cnt [NCH] = '{default: 0};
  int         wr_cnt [NCH] = '{default: 0};
  logic [4:0] p_md   [NCH] = '{default: 5'h0};
  logic [4:0] p_reg  [NCH] = '{default: 5'h0};

  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (phy_reg_rd[i]) rd_cnt[i]++;
      if (phy_reg_wr[i]) wr_cnt[i]++;
      if (phy_reg_rd[i] || phy_reg_wr[i]) begin
        p_md[i]  = phy_md_addr[5*i +: 5];
        p_reg[i] = phy_reg_addr[5*i +: 5];
      end
    end
  end

  // Register-level model of the IRQ block.
  logic [NCH-1:0] m_stat = '0;
  logic [NCH-1:0] m_mask = '0;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  function automatic logic [15:0] ca(input int ch, input int b);
    return BASE + 16'(8 + 4 * ch + b);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    wr_addr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic v);
    rd_addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    d = rd_data; v = rd_valid;
  endtask

  task automatic wait_idle(input int ch, output logic [7:0] st, output bit ok);
    logic v;
    ok = 1'b0;
    st = '0;
    for (int k = 0; k < 200; k++) begin
      bus_read(ca(ch, 3), st, v);
      if (!st[7]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d; logic v;
    rst_n = 1'b0;
    tick(3);
    tests++; if ({rd_valid, rd_data, irq, phy_reg_rd, phy_reg_wr} !== '0) begin fails++;
      $display("FAIL reset_ctrl_outs: got %h expected 0", {rd_valid, rd_data, irq, phy_reg_rd, phy_reg_wr}); end
    tests++; if (phy_wr_data !== '0) begin fails++;
      $display("FAIL reset_wr_data: got %h expected 0", phy_wr_data); end
    tests++; if ({phy_md_addr, phy_reg_addr} !== '0) begin fails++;
      $display("FAIL reset_addrs: got %h expected 0", {phy_md_addr, phy_reg_addr}); end
    rst_n = 1'b1;
    tick(2);
    bus_read(BASE, d, v);
    tests++; if ({v, d} !== 9'h100) begin fails++; $display("FAIL reset_irqstat: got %h expected 100", {v, d}); end
    bus_read(BASE + 16'd1, d, v);
    tests++; if ({v, d} !== 9'h100) begin fails++; $display("FAIL reset_irqmask: got %h expected 100", {v, d}); end
    for (int c = 0; c < NCH; c++) begin
      bus_read(ca(c, 3), d, v);
      tests++; if (d !== 8'h00) begin fails++; $display("FAIL reset_status ch%0d: got %h expected 00", c, d); end
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_unmapped();
    logic [15:0] addrs [7];
    logic [7:0] d; logic v;
    addrs = '{BASE - 16'd1, BASE + 16'd2, BASE + 16'd7, BASE + 16'(8 + 4 * NCH),
              BASE + 16'(11 + 4 * NCH), 16'h0000, 16'hFFFF};
    foreach (addrs[i]) bus_write(addrs[i], 8'hFF);
    foreach (addrs[i]) begin
      bus_read(addrs[i], d, v);
      tests++; if ({v, d} !== 9'h100) begin fails++;
        $display("FAIL unmapped_read %h: got %h expected 100", addrs[i], {v, d}); end
    end
    tick();
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_pulse: got %b expected 0", rd_valid); end
    bus_read(BASE + 16'd1, d, v);
    tests++; if (d !== 8'(m_mask)) begin fails++; $display("FAIL unmapped_mask: got %h expected %h", d, m_mask); end
    $display("[TB] test_unmapped done");
  endtask

  task automatic test_read_cmd();
    int r0, w0;
    logic [7:0] d, st; logic v; bit ok;
    r0 = rd_cnt[1]; w0 = wr_cnt[1];
    phy_rd_data[31:16] = 16'hBEEF;
    bus_write(ca(1, 2), 8'h61);
    bus_write(ca(1, 3), 8'h21);
    tick(2); mdio_busy[1] = 1'b1;
    tick(8); mdio_busy[1] = 1'b0;
    wait_idle(1, st, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL rdcmd_complete: got busy expected idle"); end
    tests++; if (st !== 8'h41) begin fails++; $display("FAIL rdcmd_status: got %h expected 41", st); end
    tests++; if ((rd_cnt[1] - r0) !== 1 || (wr_cnt[1] - w0) !== 0) begin fails++;
      $display("FAIL rdcmd_pulses: got rd=%0d wr=%0d expected rd=1 wr=0", rd_cnt[1] - r0, wr_cnt[1] - w0); end
    tests++; if ({p_md[1], p_reg[1]} !== {5'h0B, 5'h01}) begin fails++;
      $display("FAIL rdcmd_addr: got md=%h reg=%h expected md=0b reg=01", p_md[1], p_reg[1]); end
    bus_read(ca(1, 0), d, v);
    tests++; if (d !== 8'hEF) begin fails++; $display("FAIL rdcmd_data_lo: got %h expected ef", d); end
    bus_read(ca(1, 1), d, v);
    tests++; if (d !== 8'hBE) begin fails++; $display("FAIL rdcmd_data_hi: got %h expected be", d); end
    m_stat[1] = 1'b1;
    bus_read(BASE, d, v);
    tests++; if (d !== 8'h02) begin fails++; $display("FAIL rdcmd_irqstat: got %h expected 02", d); end
    $display("[TB] test_read_cmd done");
  endtask

  task automatic test_irq();
    logic [7:0] d;
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_masked: got %b expected 0", irq); end
    // Read and write IRQMASK in the same cycle: read sees the old value.
    rd_addr = BASE + 16'd1; rd_en = 1'b1;
    wr_addr = BASE + 16'd1; wr_data = 8'h02; wr_en = 1'b1;
    tick();
    rd_en = 1'b0; wr_en = 1'b0; d = rd_data;
    m_mask = 4'h2;
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL rw_same_reg: got %h expected 00", d); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_latency: got %b expected 0", irq); end
    tick();
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_unmasked: got %b expected 1", irq); end
    bus_write(BASE, 8'h02);
    m_stat[1] = 1'b0;
    tick();
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_w1c: got %b expected 0", irq); end
    $display("[TB] test_irq done");
  endtask

  task automatic test_random();
    int ch, cmdsel, dl, ln, r0, w0;
    logic [4:0] md, rg;
    logic [15:0] dat, rdv, exp_data;
    logic [7:0] lo, hi, st, d, clr, mk; logic v; bit ok, is_wr;
    for (int it = 0; it < 16; it++) begin
      ch = $urandom_range(0, NCH - 1);
      md = 5'($urandom); rg = 5'($urandom);
      dat = 16'($urandom); rdv = 16'($urandom);
      cmdsel = $urandom_range(0, 2);
      is_wr = (cmdsel != 0);
      phy_rd_data[16*ch +: 16] = rdv;
      r0 = rd_cnt[ch]; w0 = wr_cnt[ch];
      bus_write(ca(ch, 0), dat[7:0]);
      bus_write(ca(ch, 1), dat[15:8]);
      bus_write(ca(ch, 2), {md[2:0], rg});
      bus_write(ca(ch, 3), (cmdsel == 0 ? 8'h20 : cmdsel == 1 ? 8'h40 : 8'h60) | {6'b0, md[4:3]});
      dl = $urandom_range(1, 6); ln = $urandom_range(1, 12);
      tick(dl); mdio_busy[ch] = 1'b1;
      tick(ln); mdio_busy[ch] = 1'b0;
      wait_idle(ch, st, ok);
      exp_data = is_wr ? dat : rdv;
      tests++; if ({ok, st} !== {1'b1, 8'h40 | {6'b0, md[4:3]}}) begin fails++;
        $display("FAIL rand%0d_status ch%0d: got %h expected %h", it, ch, st, 8'h40 | {6'b0, md[4:3]}); end
      bus_read(ca(ch, 0), lo, v);
      bus_read(ca(ch, 1), hi, v);
      tests++; if ({hi, lo} !== exp_data) begin fails++;
        $display("FAIL rand%0d_data ch%0d: got %h expected %h", it, ch, {hi, lo}, exp_data); end
      tests++; if ((wr_cnt[ch] - w0) !== int'(is_wr) || (rd_cnt[ch] - r0) !== int'(!is_wr)) begin fails++;
        $display("FAIL rand%0d_pulses ch%0d: got rd=%0d wr=%0d expected wr=%0d", it, ch,
                 rd_cnt[ch] - r0, wr_cnt[ch] - w0, is_wr); end
      tests++; if ({p_md[ch], p_reg[ch]} !== {md, rg}) begin fails++;
        $display("FAIL rand%0d_addr ch%0d: got %h/%h expected %h/%h", it, ch, p_md[ch], p_reg[ch], md, rg); end
      if (is_wr) begin
        tests++; if (phy_wr_data[16*ch +: 16] !== dat) begin fails++;
          $display("FAIL rand%0d_wrdata ch%0d: got %h expected %h", it, ch, phy_wr_data[16*ch +: 16], dat); end
      end
      m_stat[ch] = 1'b1;
      bus_read(BASE, d, v);
      tests++; if (d !== 8'(m_stat)) begin fails++; $display("FAIL rand%0d_irqstat: got %h expected %h", it, d, m_stat); end
      clr = {4'b0, 4'($urandom)}; mk = {4'b0, 4'($urandom)};
      bus_write(BASE, clr);
      m_stat = m_stat & ~clr[NCH-1:0];
      bus_write(BASE + 16'd1, mk);
      m_mask = mk[NCH-1:0];
      tick();
      tests++; if (irq !== |(m_stat & m_mask)) begin fails++;
        $display("FAIL rand%0d_irq: got %b expected %b", it, irq, |(m_stat & m_mask)); end
      $display("[TB] random txn %0d ch%0d wr=%0d md=%h reg=%h data=%h", it, ch, is_wr, md, rg, exp_data);
    end
  endtask

  task automatic test_reject();
    int r0, w0;
    logic [7:0] d, st; logic v; bit ok;
    r0 = rd_cnt[0]; w0 = wr_cnt[0];
    bus_write(ca(0, 0), 8'h34);
    bus_write(ca(0, 1), 8'h12);
    bus_write(ca(0, 2), 8'h22);
    bus_write(ca(0, 3), 8'h40);
    tick(2); mdio_busy[0] = 1'b1;
    tick(2);
    bus_write(ca(0, 3), 8'h20);
    bus_write(ca(0, 0), 8'hAA);
    bus_read(ca(0, 3), st, v);
    tests++; if (st !== 8'hA0) begin fails++; $display("FAIL reject_status_busy: got %h expected a0", st); end
    tick(3); mdio_busy[0] = 1'b0;
    wait_idle(0, st, ok);
    tests++; if ({ok, st} !== {1'b1, 8'h60}) begin fails++; $display("FAIL reject_status_done: got %h expected 60", st); end
    tests++; if ((wr_cnt[0] - w0) !== 1 || (rd_cnt[0] - r0) !== 0) begin fails++;
      $display("FAIL reject_pulses: got rd=%0d wr=%0d expected rd=0 wr=1", rd_cnt[0] - r0, wr_cnt[0] - w0); end
    bus_read(ca(0, 0), d, v);
    tests++; if (d !== 8'h34) begin fails++; $display("FAIL reject_data_kept: got %h expected 34", d); end
    tests++; if (phy_wr_data[15:0] !== 16'h1234) begin fails++;
      $display("FAIL reject_wrdata: got %h expected 1234", phy_wr_data[15:0]); end
    m_stat[0] = 1'b1;
    $display("[TB] test_reject done");
  endtask

  task automatic test_fast();
    logic [7:0] st; logic v; bit ok;
    bus_write(ca(3, 2), 8'h05);
    bus_write(ca(3, 3), 8'h20);
    tick(8);
    bus_read(ca(3, 3), st, v);
    tests++; if (st !== 8'h80) begin fails++; $display("FAIL fast_still_waiting: got %h expected 80", st); end
    wait_idle(3, st, ok);
    tests++; if ({ok, st} !== {1'b1, 8'h40}) begin fails++; $display("FAIL fast_done: got %h expected 40", st); end
    m_stat[3] = 1'b1;
    $display("[TB] test_fast done");
  endtask

  task automatic test_set_wins();
    logic [7:0] d, st; logic v; bit ok;
    bus_write(BASE, 8'h04);
    m_stat[2] = 1'b0;
    bus_write(ca(2, 3), 8'h20);
    tick(2); mdio_busy[2] = 1'b1;
    tick(3); mdio_busy[2] = 1'b0;
    tick();
    bus_write(BASE, 8'h04);
    m_stat[2] = 1'b1;
    bus_read(BASE, d, v);
    tests++; if (d !== 8'(m_stat)) begin fails++; $display("FAIL set_wins_w1c: got %h expected %h", d, m_stat); end
    wait_idle(2, st, ok);
    $display("[TB] test_set_wins done");
  endtask

  task automatic test_timeout();
    logic [7:0] d, st; logic v; bit ok;
    phy_rd_data[63:48] = 16'hDEAD;
    bus_write(ca(3, 0), 8'h11);
    bus_write(ca(3, 1), 8'h22);
    bus_write(ca(3, 2), 8'h00);
    bus_write(ca(3, 3), 8'h20);
    tick(2); mdio_busy[3] = 1'b1;
`ifdef MGMT_MDIO_TIMEOUT_EN
    tick(TO + 20);
    bus_read(ca(3, 3), st, v);
    tests++; if (st !== 8'h60) begin fails++; $display("FAIL timeout_status: got %h expected 60", st); end
    bus_read(ca(3, 0), d, v);
    tests++; if (d !== 8'h11) begin fails++; $display("FAIL timeout_no_capture: got %h expected 11", d); end
    mdio_busy[3] = 1'b0;
`else
    tick(10000);
    bus_read(ca(3, 3), st, v);
    tests++; if (st !== 8'h80) begin fails++; $display("FAIL no_timeout_busy: got %h expected 80", st); end
    mdio_busy[3] = 1'b0;
    wait_idle(3, st, ok);
    tests++; if ({ok, st} !== {1'b1, 8'h40}) begin fails++; $display("FAIL no_timeout_done: got %h expected 40", st); end
    bus_read(ca(3, 1), d, v);
    tests++; if (d !== 8'hDE) begin fails++; $display("FAIL no_timeout_capture: got %h expected de", d); end
`endif
    m_stat[3] = 1'b1;
    tick(3);
    $display("[TB] test_timeout done");
  endtask

  task automatic test_reset_mid();
    int r0 [NCH]; int w0 [NCH];
    logic [7:0] d; logic v;
    bus_write(BASE + 16'd1, 8'h0F);
    m_mask = 4'hF;
    tick();
    tests++; if (irq !== |(m_stat & m_mask)) begin fails++;
      $display("FAIL pre_reset_irq: got %b expected %b", irq, |(m_stat & m_mask)); end
    bus_write(ca(0, 3), 8'h40);
    tick(2); mdio_busy[0] = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    tests++; if ({irq, phy_reg_rd, phy_reg_wr} !== '0) begin fails++;
      $display("FAIL async_reset: got %h expected 0", {irq, phy_reg_rd, phy_reg_wr}); end
    tick(2);
    rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) begin r0[c] = rd_cnt[c]; w0[c] = wr_cnt[c]; end
    tick(5); mdio_busy[0] = 1'b0;
    tick(20);
    for (int c = 0; c < NCH; c++) begin
      tests++; if (rd_cnt[c] !== r0[c] || wr_cnt[c] !== w0[c]) begin fails++;
        $display("FAIL post_reset_pulse ch%0d: got rd+%0d wr+%0d expected none", c, rd_cnt[c] - r0[c], wr_cnt[c] - w0[c]); end
      bus_read(ca(c, 3), d, v);
      tests++; if (d !== 8'h00) begin fails++; $display("FAIL post_reset_status ch%0d: got %h expected 00", c, d); end
    end
    m_stat = '0; m_mask = '0;
    bus_read(BASE, d, v);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL post_reset_irqstat: got %h expected 00", d); end
    bus_read(BASE + 16'd1, d, v);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL post_reset_irqmask: got %h expected 00", d); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL post_reset_irq: got %b expected 0", irq); end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_unmapped();
    test_read_cmd();
    test_irq();
    test_random();
    test_reject();
    test_fast();
    test_set_wins();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
